adsr_envelope: RTL and testbench

Per-voice ADSR amplitude envelope that sits directly downstream of the waveform generator sum. It scales the unsigned offset-binary `Waveform` sample around mid-scale by an 8-bit envelope level. The level is driven by a gate-controlled Attack/Decay/Sustain/Release state machine stepped by a prescaled tick. The output feeds the channel output stage in place of the raw waveform.

---
 rtl/adsr_envelope.sv | 129 ++++++++++++
 tb/tb_adsr_envelope.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - per-voice ADSR envelope scaling an offset-binary waveform around mid-scale.
// Optional feature: define ADSR_HARD_RESTART_EN to zero the envelope on every gate rise.
module adsr_envelope #(
  parameter int WAVE_DEPTH = 8,
  parameter int PRESCALE   = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Gate,
  input  logic [7:0]            AttackRate,
  input  logic [7:0]            DecayRate,
  input  logic [7:0]            Sustain,
  input  logic [7:0]            ReleaseRate,
  input  logic [WAVE_DEPTH-1:0] WaveIn,
  output logic [WAVE_DEPTH-1:0] WaveOut,
  output logic [7:0]            Level,
  output logic [2:0]            State,
  output logic                  Active
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [WAVE_DEPTH-1:0] MID = {1'b1, {(WAVE_DEPTH-1){1'b0}}};
  localparam int PW = WAVE_DEPTH + 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] env, env_nxt;
  logic [15:0] presc;
  logic        gate_q;
  logic        tick, rise, fall;
  logic [16:0] att_sum, dec_diff, rel_diff;
  logic [15:0] sus_lvl;

  assign tick = (presc == PS_LAST);
  assign rise = Gate & ~gate_q;
  assign fall = ~Gate & gate_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc  <= '0;
      gate_q <= 1'b0;
      state  <= IDLE;
      env    <= '0;
    end else begin
      presc  <= tick ? 16'd0 : presc + 16'd1;
      gate_q <= Gate;
      state  <= state_nxt;
      env    <= env_nxt;
    end
  end

  // Gate edges win over a coincident tick: that cycle applies no envelope step.
  always_comb begin
    sus_lvl   = {Sustain, 8'h00};
    att_sum   = {1'b0, env} + {1'b0, AttackRate, 8'h00};
    dec_diff  = {1'b0, env} - {1'b0, DecayRate, 8'h00};
    rel_diff  = {1'b0, env} - {1'b0, ReleaseRate, 8'h00};
    state_nxt = state;
    env_nxt   = env;
    if (rise && (state == IDLE || state == RELEASE)) begin
      state_nxt = ATTACK;
`ifdef ADSR_HARD_RESTART_EN
      env_nxt = 16'h0000;
`endif
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nxt = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (AttackRate == 8'h00 || att_sum >= 17'h0FFFF) begin
            env_nxt   = 16'hFFFF;
            state_nxt = DECAY;
          end else begin
            env_nxt = att_sum[15:0];
          end
        end
        DECAY: begin
          if (DecayRate == 8'h00 || dec_diff[16] || dec_diff[15:0] <= sus_lvl) begin
            env_nxt   = sus_lvl;
            state_nxt = SUSTAIN;
          end else begin
            env_nxt = dec_diff[15:0];
          end
        end
        SUSTAIN: env_nxt = sus_lvl;
        RELEASE: begin
          if (ReleaseRate == 8'h00 || rel_diff[16] || rel_diff[15:0] == 16'h0000) begin
            env_nxt   = 16'h0000;
            state_nxt = IDLE;
          end else begin
            env_nxt = rel_diff[15:0];
          end
        end
        default: env_nxt = env;
      endcase
    end
  end

  assign Level  = env[15:8];
  assign State  = state;
  assign Active = (state != IDLE);

  logic signed [WAVE_DEPTH:0] wave_d;
  logic signed [PW-1:0]       prod, prod_q;
  logic                       unused_prod_lsb;

  // |d * Level| < 2^(WAVE_DEPTH+7), so PW signed bits hold the product exactly.
  assign wave_d = $signed({1'b0, WaveIn}) - $signed({1'b0, MID});
  assign prod   = PW'(wave_d) * PW'($signed({1'b0, Level}));
  assign unused_prod_lsb = ^prod_q[7:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prod_q  <= '0;
      WaveOut <= MID;
    end else begin
      prod_q  <= prod;
      WaveOut <= MID + prod_q[PW-1:8];
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - scoreboard bench for adsr_envelope with a spec-level reference model.
// Honours ADSR_HARD_RESTART_EN when defined for the build.
module tb_adsr_envelope;
  localparam int PS = 4;
  localparam int M  = 128;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Gate = 1'b0;
  logic [7:0] AttackRate = 8'h00, DecayRate = 8'h00, Sustain = 8'h00, ReleaseRate = 8'h00;
  logic [7:0] WaveIn = 8'h00;
  logic [7:0] WaveOut, Level;
  logic [2:0] State;
  logic       Active;

  always #5 Clock = ~Clock;

  adsr_envelope #(.WAVE_DEPTH(8), .PRESCALE(PS)) dut (
    .Clock(Clock), .Reset(Reset), .Gate(Gate),
    .AttackRate(AttackRate), .DecayRate(DecayRate), .Sustain(Sustain), .ReleaseRate(ReleaseRate),
    .WaveIn(WaveIn), .WaveOut(WaveOut), .Level(Level), .State(State), .Active(Active)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int floor_div256(input int p);
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  // Reference model: envelope as a plain integer 0..65535, state as 0..4.
  int menv, mstate, mcnt;
  bit mgq;
  int wq[$];
  int sq_state[$];
  int sq_level[$];

  always @(posedge Clock or negedge Reset) begin : model
    int lvl, tgt, step_v;
    bit rise, fall, tick;
    if (!Reset) begin
      menv = 0; mstate = 0; mcnt = 0; mgq = 0;
      wq.delete(); sq_state.delete(); sq_level.delete();
    end else begin
      lvl = menv / 256;
      wq.push_back(M + floor_div256((int'(WaveIn) - M) * lvl));
      rise = Gate && !mgq;
      fall = !Gate && mgq;
      tick = (mcnt == PS - 1);
      tgt  = int'(Sustain) * 256;
      if (rise && (mstate == 0 || mstate == 4)) begin
        mstate = 1;
`ifdef ADSR_HARD_RESTART_EN
        menv = 0;
`endif
      end else if (fall && mstate >= 1 && mstate <= 3) begin
        mstate = 4;
      end else if (tick) begin
        if (mstate == 1) begin
          step_v = int'(AttackRate) * 256;
          if (step_v == 0 || menv + step_v >= 65535) begin menv = 65535; mstate = 2; end
          else menv = menv + step_v;
        end else if (mstate == 2) begin
          step_v = int'(DecayRate) * 256;
          if (step_v == 0 || menv - step_v <= tgt) begin menv = tgt; mstate = 3; end
          else menv = menv - step_v;
        end else if (mstate == 3) begin
          menv = tgt;
        end else if (mstate == 4) begin
          step_v = int'(ReleaseRate) * 256;
          if (step_v == 0 || menv - step_v <= 0) begin menv = 0; mstate = 0; end
          else menv = menv - step_v;
        end
      end
      mgq  = Gate;
      mcnt = (mcnt == PS - 1) ? 0 : mcnt + 1;
      sq_state.push_back(mstate);
      sq_level.push_back(menv / 256);
    end
  end

  // Monitor: state/level expected right after each edge, waveform two edges after its push.
  always @(negedge Clock) begin : monitor
    int es, el;
    if (Reset) begin
      if (sq_state.size() > 0) begin
        es = sq_state.pop_front();
        el = sq_level.pop_front();
        chk("sb_state", int'(State), es);
        chk("sb_level", int'(Level), el);
        chk("sb_active", int'(Active), (es != 0) ? 1 : 0);
      end
      if (wq.size() > 1) chk("sb_waveout", int'(WaveOut), wq.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_state(input int s, input int maxc);
    int n = 0;
    while (int'(State) != s && n < maxc) begin
      step(1);
      n++;
    end
    chk("wait_state", int'(State), s);
  endtask

  function automatic logic [7:0] rnd_rate();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom_range(16, 255));
    endcase
  endfunction

  int ramp_exp[4] = '{8'h40, 8'h80, 8'hC0, 8'hFF};

  initial begin : stim
    int seen[$];
    int last, n, changes;

    Reset = 1'b0; WaveIn = 8'hFF;
    step(3);
    chk("reset_waveout", int'(WaveOut), 8'h80);
    chk("reset_level", int'(Level), 0);
    chk("reset_state", int'(State), 0);
    chk("reset_active", int'(Active), 0);

    AttackRate = 8'h00; DecayRate = 8'h00; Sustain = 8'hFF; ReleaseRate = 8'h10; WaveIn = 8'h80;
    Reset = 1'b1;
    step(2);
    Gate = 1'b1;
    step(1);
    chk("instant_attack_state", int'(State), 1);
    wait_state(3, 4 * PS);
    chk("sustain_ff_level", int'(Level), 8'hFF);

    WaveIn = 8'hFF; step(2); chk("scale_ff_in_ff", int'(WaveOut), 8'hFE);
    WaveIn = 8'h00; step(2); chk("scale_ff_in_00", int'(WaveOut), 8'h00);
    WaveIn = 8'h80; step(2); chk("scale_ff_in_80", int'(WaveOut), 8'h80);
    Sustain = 8'h80; step(2 * PS);
    chk("live_sustain_80", int'(Level), 8'h80);
    WaveIn = 8'hFF; step(2); chk("scale_80_in_ff", int'(WaveOut), 8'hBF);

    // Retrigger on a tick cycle during release: no release step that cycle.
    Sustain = 8'h30; step(2 * PS);
    chk("sustain_30_level", int'(Level), 8'h30);
    Gate = 1'b0; step(1);
    chk("fall_to_release", int'(State), 4);
    n = 0;
    while (mcnt != PS - 1 && n < 2 * PS) begin step(1); n++; end
    chk("release_level_before_retrig", int'(Level), 8'h30);
    Gate = 1'b1; step(1);
    chk("retrig_state", int'(State), 1);
`ifdef ADSR_HARD_RESTART_EN
    chk("retrig_level", int'(Level), 0);
`else
    chk("retrig_level", int'(Level), 8'h30);
`endif

    Gate = 1'b0; ReleaseRate = 8'h00;
    wait_state(0, 4 * PS);
    AttackRate = 8'h40; DecayRate = 8'h10; Sustain = 8'h20;
    Gate = 1'b1;
    last = int'(Level); n = 0;
    while (int'(State) != 2 && n < 8 * PS) begin
      step(1); n++;
      if (int'(Level) != last) begin seen.push_back(int'(Level)); last = int'(Level); end
    end
    chk("ramp_steps", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ramp_level_%0d", i), (seen.size() > i) ? seen[i] : -1, ramp_exp[i]);
    chk("ramp_to_decay", int'(State), 2);

    wait_state(3, 40 * PS);
    Sustain = 8'h40; step(2 * PS);
    chk("sustain_40_level", int'(Level), 8'h40);
    ReleaseRate = 8'h10; Gate = 1'b0; step(1);
    chk("release_state", int'(State), 4);
    last = int'(Level); n = 0; changes = 0;
    while (int'(State) != 0 && n < 8 * PS) begin
      step(1); n++;
      if (int'(Level) != last) begin changes++; last = int'(Level); end
    end
    chk("release_ticks", changes, 4);
    chk("release_end_level", int'(Level), 0);
    chk("release_end_active", int'(Active), 0);

    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) Gate = ~Gate;
      if ($urandom_range(0, 49) == 0) AttackRate = rnd_rate();
      if ($urandom_range(0, 49) == 0) DecayRate = rnd_rate();
      if ($urandom_range(0, 49) == 0) ReleaseRate = rnd_rate();
      if ($urandom_range(0, 39) == 0) Sustain = 8'($urandom_range(0, 255));
      WaveIn = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) == 0) begin
        Reset = 1'b0; step(2);
        chk("midnote_reset_level", int'(Level), 0);
        chk("midnote_reset_waveout", int'(WaveOut), 8'h80);
        Reset = 1'b1;
      end
      step(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
